// File: rtl/rdp_systolic_arb.sv
// Round-robin burst arbiter sharing one rdp systolic row-pair port among N_REQ producers.
// Optional macro RDP_ARB_IDLE_HOLD_EN keeps a grant through up to IDLE_TO-1 idle request cycles.
module rdp_systolic_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned BURST   = 8,
    parameter int unsigned IDLE_TO = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [N_REQ-1:0]                            t_req,
    output logic [N_REQ-1:0]                            t_ack,
    output logic                                        i_req,
    input  logic                                        i_ack,
    output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0]  i_sel,
    output logic                                        grant_vld,
    output logic [7:0]                                  beat_cnt
);

    localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [SW-1:0] LastIdx = SW'(N_REQ - 1);
    localparam logic [7:0] LastBeat = 8'(BURST - 1);

    if (N_REQ < 1 || N_REQ > 16) begin : g_bad_n_req
        $error("N_REQ out of range");
    end
    if (BURST < 1 || BURST > 256) begin : g_bad_burst
        $error("BURST out of range");
    end
    if (IDLE_TO < 1 || IDLE_TO > 15) begin : g_bad_idle_to
        $error("IDLE_TO out of range");
    end

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [7:0]      cnt_q, cnt_d;
`ifdef RDP_ARB_IDLE_HOLD_EN
    localparam logic [3:0] IdleTo = 4'(IDLE_TO);
    logic [3:0]      idle_q, idle_d;
`endif

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               win_found;
    logic [SW:0]        win_sum;
    logic [SW-1:0]      winner;
    logic [SW-1:0]      sel_next;
    logic               cur_req;
    logic               beat;
    logic               rel_grant;

    // Rotate requests so bit 0 is the producer at ptr; first set bit wins.
    always_comb begin
        req_dbl   = {t_req, t_req} >> ptr_q;
        req_rot   = req_dbl[N_REQ-1:0];
        win_found = 1'b0;
        win_sum   = '0;
        for (int j = 0; j < int'(N_REQ); j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr_q} + (SW+1)'(j);
            end
        end
        if (win_sum >= (SW+1)'(N_REQ)) begin
            win_sum = win_sum - (SW+1)'(N_REQ);
        end
        winner = win_sum[SW-1:0];
    end

    always_comb begin
        cur_req = 1'b0;
        t_ack   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (sel_q == SW'(k)) begin
                cur_req = t_req[k];
                t_ack[k] = (state_q == StBurst) && !reset && i_ack && t_req[k];
            end
        end
        i_req     = (state_q == StBurst) && cur_req && !reset;
        beat      = i_req && i_ack;
        grant_vld = (state_q == StBurst);
        i_sel     = sel_q;
        beat_cnt  = cnt_q;
        sel_next  = (sel_q == LastIdx) ? '0 : sel_q + SW'(1);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rel_grant = 1'b0;
`ifdef RDP_ARB_IDLE_HOLD_EN
        idle_d    = idle_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StBurst;
                    sel_d   = winner;
                    cnt_d   = '0;
`ifdef RDP_ARB_IDLE_HOLD_EN
                    idle_d  = '0;
`endif
                end
            end
            StBurst: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LastBeat) rel_grant = 1'b1;
                end
`ifdef RDP_ARB_IDLE_HOLD_EN
                if (cur_req) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 4'd1;
                    if (idle_d == IdleTo) rel_grant = 1'b1;
                end
`else
                if (!cur_req) rel_grant = 1'b1;
`endif
                if (rel_grant) begin
                    state_d = StIdle;
                    ptr_d   = sel_next;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
`ifdef RDP_ARB_IDLE_HOLD_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
`ifdef RDP_ARB_IDLE_HOLD_EN
            idle_q  <= idle_d;
`endif
        end
    end

endmodule
